// File: rtl/cw305_ml_pkg.sv
// Shared constants for the CW305 ML register block: register map and bias field width.
package cw305_ml_pkg;

    localparam int unsigned ADDR_INPUTS  = 32'h04;
    localparam int unsigned ADDR_WEIGHTS = 32'h05;
    localparam int unsigned ADDR_BIAS    = 32'h06;
    localparam int unsigned ADDR_OUTPUTS = 32'h07;

    localparam int unsigned BIAS_W = 4;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_INPUTS,
        SEL_WEIGHTS,
        SEL_BIAS,
        SEL_OUTPUTS
    } reg_sel_e;

endpackage

// File: rtl/ml_neuron_array.sv
// Combinational binary-input neuron layer: popcount(inputs & weight row) + signed bias >= 0.
module ml_neuron_array
    import cw305_ml_pkg::*;
#(
    parameter int unsigned pINPUTCNT  = 4,
    parameter int unsigned pOUTPUTCNT = 4
) (
    input  logic [pINPUTCNT-1:0]            inputs,
    input  logic [pOUTPUTCNT*pINPUTCNT-1:0] weights,
    input  logic [pOUTPUTCNT*BIAS_W-1:0]    bias,
    output logic [pOUTPUTCNT-1:0]           result_c
);

    // Wide enough that the full popcount plus the most negative bias cannot wrap.
    localparam int unsigned SUM_W = $clog2(pINPUTCNT + 1) + 5;

    for (genvar j = 0; j < pOUTPUTCNT; j++) begin : g_neuron
        logic [SUM_W-1:0] sum_c;

        always_comb begin
            sum_c = {{(SUM_W - BIAS_W){bias[j*BIAS_W + BIAS_W - 1]}}, bias[j*BIAS_W +: BIAS_W]};
            for (int i = 0; i < pINPUTCNT; i++) begin
                sum_c = sum_c + SUM_W'(inputs[i] & weights[j*pINPUTCNT + i]);
            end
        end

        assign result_c[j] = ~sum_c[SUM_W-1];
    end

endmodule

// File: rtl/cw305_reg_ml.sv
// CW305 USB register block holding a small neuron layer's inputs, weights and biases,
// with a registered classifier result readable at OUTPUTS and on ml_out.
module cw305_reg_ml
    import cw305_ml_pkg::*;
#(
    parameter int unsigned pADDR_WIDTH   = 21,
    parameter int unsigned pBYTECNT_SIZE = 7,
    parameter int unsigned pWEIGHTCNT    = 16,
    parameter int unsigned pINPUTCNT     = 4,
    parameter int unsigned pBIASCNT      = 16,
    parameter int unsigned pOUTPUTCNT    = 4
) (
    input  logic                                 usb_clk,
    input  logic                                 reset_i,
    input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    input  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    input  logic [7:0]                           write_data,
    output logic [7:0]                           read_data,
    input  logic                                 reg_read,
    input  logic                                 reg_write,
    input  logic                                 reg_addrvalid,
    output logic [pOUTPUTCNT-1:0]                ml_out
);

    localparam int unsigned ADDR_W = pADDR_WIDTH - pBYTECNT_SIZE;

    logic [pINPUTCNT-1:0]  inputs_q;
    logic [pWEIGHTCNT-1:0] weights_q;
    logic [pBIASCNT-1:0]   bias_q;
    logic [pOUTPUTCNT-1:0] outputs_q;
    logic [pOUTPUTCNT-1:0] result_c;
    logic [7:0]            rd_byte_c;
    reg_sel_e              sel_c;

    ml_neuron_array #(
        .pINPUTCNT (pINPUTCNT),
        .pOUTPUTCNT(pOUTPUTCNT)
    ) u_neurons (
        .inputs  (inputs_q),
        .weights (weights_q),
        .bias    (bias_q),
        .result_c(result_c)
    );

    // Address decode
    always_comb begin
        sel_c = SEL_NONE;
        if (reg_address == ADDR_W'(ADDR_INPUTS))       sel_c = SEL_INPUTS;
        else if (reg_address == ADDR_W'(ADDR_WEIGHTS)) sel_c = SEL_WEIGHTS;
        else if (reg_address == ADDR_W'(ADDR_BIAS))    sel_c = SEL_BIAS;
        else if (reg_address == ADDR_W'(ADDR_OUTPUTS)) sel_c = SEL_OUTPUTS;
    end

    // Read byte mux; bits past a register's width and unmapped addresses read as zero
    always_comb begin
        rd_byte_c = '0;
        case (sel_c)
            SEL_INPUTS:
                for (int k = 0; k < pINPUTCNT; k++)
                    if (reg_bytecnt == pBYTECNT_SIZE'(k / 8)) rd_byte_c[3'(k % 8)] = inputs_q[k];
            SEL_WEIGHTS:
                for (int k = 0; k < pWEIGHTCNT; k++)
                    if (reg_bytecnt == pBYTECNT_SIZE'(k / 8)) rd_byte_c[3'(k % 8)] = weights_q[k];
            SEL_BIAS:
                for (int k = 0; k < pBIASCNT; k++)
                    if (reg_bytecnt == pBYTECNT_SIZE'(k / 8)) rd_byte_c[3'(k % 8)] = bias_q[k];
            SEL_OUTPUTS:
                for (int k = 0; k < pOUTPUTCNT; k++)
                    if (reg_bytecnt == pBYTECNT_SIZE'(k / 8)) rd_byte_c[3'(k % 8)] = outputs_q[k];
            default: rd_byte_c = '0;
        endcase
    end

    // Register writes, result capture and registered read port
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            inputs_q  <= '0;
            weights_q <= '0;
            bias_q    <= '0;
            outputs_q <= '1;
            read_data <= '0;
        end else begin
            outputs_q <= result_c;
            if (reg_write && reg_addrvalid) begin
                case (sel_c)
                    SEL_INPUTS:
                        for (int k = 0; k < pINPUTCNT; k++)
                            if (reg_bytecnt == pBYTECNT_SIZE'(k / 8)) inputs_q[k] <= write_data[3'(k % 8)];
                    SEL_WEIGHTS:
                        for (int k = 0; k < pWEIGHTCNT; k++)
                            if (reg_bytecnt == pBYTECNT_SIZE'(k / 8)) weights_q[k] <= write_data[3'(k % 8)];
                    SEL_BIAS:
                        for (int k = 0; k < pBIASCNT; k++)
                            if (reg_bytecnt == pBYTECNT_SIZE'(k / 8)) bias_q[k] <= write_data[3'(k % 8)];
                    default: ;
                endcase
            end
            if (reg_read && reg_addrvalid) read_data <= rd_byte_c;
        end
    end

    assign ml_out = outputs_q;

endmodule

// File: tb/tb_cw305_reg_ml.sv
// Directed self-checking bench for cw305_reg_ml: register access, neuron results, reset.
module tb_cw305_reg_ml;

    localparam int ADDR_W = 14;

    logic              usb_clk = 1'b0;
    logic              reset_i = 1'b1;
    logic [ADDR_W-1:0] reg_address = '0;
    logic [6:0]        reg_bytecnt = '0;
    logic [7:0]        write_data = '0;
    logic [7:0]        read_data;
    logic              reg_read = 1'b0;
    logic              reg_write = 1'b0;
    logic              reg_addrvalid = 1'b0;
    logic [3:0]        ml_out;

    int n_checks = 0;
    int n_errors = 0;

    cw305_reg_ml dut (
        .usb_clk      (usb_clk),
        .reset_i      (reset_i),
        .reg_address  (reg_address),
        .reg_bytecnt  (reg_bytecnt),
        .write_data   (write_data),
        .read_data    (read_data),
        .reg_read     (reg_read),
        .reg_write    (reg_write),
        .reg_addrvalid(reg_addrvalid),
        .ml_out       (ml_out)
    );

    always #5 usb_clk = ~usb_clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge usb_clk);
    endtask

    task automatic write_reg(input int addr, input int bc, input logic [7:0] d);
        @(negedge usb_clk);
        reg_address   = ADDR_W'(addr);
        reg_bytecnt   = 7'(bc);
        write_data    = d;
        reg_write     = 1'b1;
        reg_addrvalid = 1'b1;
        @(negedge usb_clk);
        reg_write     = 1'b0;
        reg_addrvalid = 1'b0;
    endtask

    task automatic read_reg(input int addr, input int bc, output logic [7:0] d);
        @(negedge usb_clk);
        reg_address   = ADDR_W'(addr);
        reg_bytecnt   = 7'(bc);
        reg_read      = 1'b1;
        reg_addrvalid = 1'b1;
        @(negedge usb_clk);
        reg_read      = 1'b0;
        reg_addrvalid = 1'b0;
        d = read_data;
    endtask

    task automatic check_rd(input string tag, input int addr, input int bc, input logic [7:0] exp);
        logic [7:0] d;
        read_reg(addr, bc, d);
        check_eq(tag, 16'(d), 16'(exp));
    endtask

    // Write all three config registers, then let OUTPUTS settle
    task automatic load(input logic [7:0] inp, input logic [15:0] w, input logic [15:0] b);
        logic [7:0] wb [4];
        wb[0] = w[7:0];
        wb[1] = w[15:8];
        wb[2] = b[7:0];
        wb[3] = b[15:8];
        write_reg(4, 0, inp);
        write_reg(5, 0, wb[0]);
        write_reg(5, 1, wb[1]);
        write_reg(6, 0, wb[2]);
        write_reg(6, 1, wb[3]);
        idle(2);
    endtask

    initial begin
        logic [7:0] held;

        repeat (3) @(negedge usb_clk);
        reset_i = 1'b0;
        check_eq("rst_ml_out", 16'(ml_out), 16'hF);
        check_eq("rst_read_data", 16'(read_data), 16'h00);
        check_rd("rst_inputs", 4, 0, 8'h00);
        check_rd("rst_weights_b1", 5, 1, 8'h00);
        check_rd("rst_bias_b0", 6, 0, 8'h00);
        check_rd("rst_outputs", 7, 0, 8'h0F);

        write_reg(4, 0, 8'h01);
        check_rd("inputs_wr", 4, 0, 8'h01);

        // Bias 0 everywhere: every neuron fires
        write_reg(5, 0, 8'hFF);
        write_reg(5, 1, 8'hFF);
        write_reg(6, 0, 8'h00);
        write_reg(6, 1, 8'h00);
        idle(2);
        check_rd("bias0_outputs", 7, 0, 8'h0F);
        check_eq("bias0_ml_out", 16'(ml_out), 16'hF);

        // No active inputs and bias -1: nothing fires
        load(8'h00, 16'hFFFF, 16'hFFFF);
        check_rd("neg_bias_outputs", 7, 0, 8'h00);
        check_eq("neg_bias_ml_out", 16'(ml_out), 16'h0);

        // Mixed: sums 0,-1,0,0 -> 4'b1101
        load(8'h03, 16'hC301, 16'h0EFF);
        check_rd("mixed_outputs", 7, 0, 8'h0D);
        check_rd("mixed_bias_b1", 6, 1, 8'h0E);

        // Extreme bias: neuron 3 sees 4 + (-8) = -4, neuron 2 sees +7
        load(8'h0F, 16'hF000, 16'h8710);
        check_eq("extreme_ml_out", 16'(ml_out), 16'h7);

        // Bits above the 4-bit INPUTS register are discarded
        write_reg(4, 0, 8'hF3);
        check_rd("inputs_trunc", 4, 0, 8'h03);

        // Ignored writes: out-of-range byte, unmapped address, read-only OUTPUTS
        write_reg(5, 5, 8'hAA);
        write_reg(9, 0, 8'hAA);
        write_reg(7, 0, 8'hAA);
        check_rd("weights_b0_kept", 5, 0, 8'h00);
        check_rd("weights_b1_kept", 5, 1, 8'hF0);
        check_rd("weights_b5_zero", 5, 5, 8'h00);
        check_rd("unmapped_zero", 9, 0, 8'h00);
        idle(2);
        check_rd("outputs_ro", 7, 0, 8'h07);

        // read_data holds while reg_read is low
        read_reg(6, 1, held);
        idle(3);
        check_eq("read_hold", 16'(read_data), 16'h87);

        // Simultaneous read and write returns the pre-write value
        write_reg(4, 0, 8'h01);
        @(negedge usb_clk);
        reg_address   = ADDR_W'(4);
        reg_bytecnt   = 7'd0;
        write_data    = 8'h03;
        reg_write     = 1'b1;
        reg_read      = 1'b1;
        reg_addrvalid = 1'b1;
        @(negedge usb_clk);
        reg_write     = 1'b0;
        reg_read      = 1'b0;
        reg_addrvalid = 1'b0;
        check_eq("rw_old_value", 16'(read_data), 16'h01);
        check_rd("rw_new_value", 4, 0, 8'h03);

        // Load non-zero state giving outputs 4'b1110, then reset during a write
        load(8'h01, 16'hFFFE, 16'hFFFF);
        check_rd("pre_reset_outputs", 7, 0, 8'h0E);
        check_rd("pre_reset_inputs", 4, 0, 8'h01);
        @(negedge usb_clk);
        reset_i       = 1'b1;
        reg_address   = ADDR_W'(4);
        reg_bytecnt   = 7'd0;
        write_data    = 8'h05;
        reg_write     = 1'b1;
        reg_addrvalid = 1'b1;
        @(negedge usb_clk);
        reset_i       = 1'b0;
        reg_write     = 1'b0;
        reg_addrvalid = 1'b0;
        check_eq("reset_ml_out", 16'(ml_out), 16'hF);
        check_eq("reset_read_data", 16'(read_data), 16'h00);
        check_rd("reset_inputs", 4, 0, 8'h00);
        check_rd("reset_weights_b0", 5, 0, 8'h00);
        check_rd("reset_weights_b1", 5, 1, 8'h00);
        check_rd("reset_bias_b0", 6, 0, 8'h00);
        check_rd("reset_bias_b1", 6, 1, 8'h00);
        check_rd("reset_outputs", 7, 0, 8'h0F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
